spi_master_mode1: RTL and testbench

Master end of the SPI mode-1 (CPOL=0, CPHA=1) link that drives the RED/BLUE LED slave. On a start request it asserts chipSelect and generates SCLK from the system clock. It shifts out one 16-bit frame, red byte then blue byte, MSB first, while capturing the 16 bits the slave returns on MISO. It sits between the host control logic and the SPI pins.

---
 rtl/spi_master_mode1.sv | 101 ++++++++++
 tb/tb_spi_master_mode1.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/spi_master_mode1.sv
// spi_master_mode1: SPI mode-1 master sending one red/blue LED frame and capturing the slave reply
module spi_master_mode1 #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] red_data,
    input  logic [6:0] blue_data,
    output logic       busy,
    output logic       done,
    output logic [7:0] rx_red,
    output logic [7:0] rx_blue,
    output logic       SCLK,
    output logic       chipSelect,
    output logic       MOSI,
    input  logic       MISO
);
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;
    localparam logic [7:0] HP_LAST = 8'(CLK_DIV - 1);
    state_t      state, state_d;
    logic [7:0]  hp, hp_d;
    logic [4:0]  edges, edges_d;
    logic [15:0] tx, tx_d, rx, rx_d;
    logic        sclk_d, mosi_d, hp_end;
    assign hp_end = hp == HP_LAST;
    // Sequencing: every timed state ends when the half-period counter wraps; even edge counts mean SCLK is high
    always_comb begin
        state_d = state;
        hp_d    = (state == IDLE || hp_end) ? 8'd0 : hp + 8'd1;
        edges_d = edges;
        tx_d    = tx;
        rx_d    = rx;
        sclk_d  = SCLK;
        mosi_d  = MOSI;
        case (state)
            IDLE: if (start) begin
                state_d = SETUP;
                tx_d    = {red_data, 1'b0, blue_data, 1'b0};
            end
            SETUP: if (hp_end) begin
                state_d = SHIFT;
                sclk_d  = 1'b1;
                mosi_d  = tx[15];
                tx_d    = {tx[14:0], 1'b0};
                edges_d = 5'd0;
            end
            SHIFT: if (hp_end) begin
                if (!edges[0]) begin
                    sclk_d  = 1'b0;
                    rx_d    = {rx[14:0], MISO};
                    edges_d = edges + 5'd1;
                end else if (edges == 5'd31) begin
                    state_d = HOLD;
                end else begin
                    sclk_d  = 1'b1;
                    mosi_d  = tx[15];
                    tx_d    = {tx[14:0], 1'b0};
                    edges_d = edges + 5'd1;
                end
            end
            HOLD: if (hp_end) begin
                state_d = DONE;
                mosi_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end
    // State and registered pin/status outputs; received bytes are published only on entry to DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            hp         <= 8'd0;
            edges      <= 5'd0;
            tx         <= 16'h0000;
            rx         <= 16'h0000;
            SCLK       <= 1'b0;
            MOSI       <= 1'b0;
            chipSelect <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            rx_red     <= 8'h00;
            rx_blue    <= 8'h00;
        end else begin
            state      <= state_d;
            hp         <= hp_d;
            edges      <= edges_d;
            tx         <= tx_d;
            rx         <= rx_d;
            SCLK       <= sclk_d;
            MOSI       <= mosi_d;
            chipSelect <= state_d inside {SETUP, SHIFT, HOLD};
            busy       <= state_d inside {SETUP, SHIFT, HOLD};
            done       <= state_d == DONE;
            if (state_d == DONE) begin
                rx_red  <= rx[15:8];
                rx_blue <= rx[7:0];
            end
        end
    end
endmodule

// File: tb/tb_spi_master_mode1.sv
// tb_spi_master_mode1: directed checks of the SPI mode-1 master with a loopback slave model
module tb_spi_master_mode1;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, miso = 1'b0;
    logic [6:0]  red_data = 7'h00, blue_data = 7'h00;
    logic        busy, done, sclk, chip_select, mosi;
    logic [7:0]  rx_red, rx_blue;
    logic [15:0] slave_word = 16'h0000, slave_sr = 16'h0000, mosi_cap = 16'h0000;
    logic        sclk_prev = 1'b0, cs_prev = 1'b0;
    int          rises = 0, run = 0, bad = 0, cs_len = 0;
    int          checks = 0, errors = 0;
    int          dc, toggles, dones;

    spi_master_mode1 #(.CLK_DIV(4)) dut (
        .clk(clk), .rst(rst), .start(start), .red_data(red_data), .blue_data(blue_data),
        .busy(busy), .done(done), .rx_red(rx_red), .rx_blue(rx_blue),
        .SCLK(sclk), .chipSelect(chip_select), .MOSI(mosi), .MISO(miso)
    );

    always #5 clk = ~clk;

    // Slave model and pin monitor: shifts slave_word out on each SCLK rise, captures MOSI, times SCLK phases
    always @(posedge clk) begin
        if (chip_select && !cs_prev) begin
            rises    <= 0;
            run      <= 0;
            bad      <= 0;
            cs_len   <= 1;
            mosi_cap <= 16'h0000;
            slave_sr <= slave_word;
        end else begin
            if (chip_select) cs_len <= cs_len + 1;
            if (sclk != sclk_prev) begin
                run <= 1;
                if (sclk) begin
                    rises    <= rises + 1;
                    mosi_cap <= {mosi_cap[14:0], mosi};
                    miso     <= slave_sr[15];
                    slave_sr <= {slave_sr[14:0], 1'b0};
                    if (rises != 0 && run != 4) bad <= bad + 1;
                end else if (run != 4) begin
                    bad <= bad + 1;
                end
            end else begin
                run <= run + 1;
            end
        end
        sclk_prev <= sclk;
        cs_prev   <= chip_select;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; start is sampled at the next posedge (cycle 0), dc is the cycle done is seen
    task automatic run_frame(input logic [6:0] r, input logic [6:0] b, input logic [15:0] s,
                             input bit scramble, output int d);
        red_data   = r;
        blue_data  = b;
        slave_word = s;
        start      = 1'b1;
        d          = -1;
        for (int k = 1; k <= 400 && d < 0; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (scramble) begin
                red_data  = 7'($urandom);
                blue_data = 7'($urandom);
            end
            if (k == 1) check("cs_rise", {31'd0, chip_select}, 32'd1);
            if (k == 4) check("setup_sclk_low", {31'd0, sclk}, 32'd0);
            if (k == 5) check("first_rise", {30'd0, sclk, mosi}, {30'd0, 1'b1, s == s ? 1'b0 : 1'b0} | {30'd0, 1'b1, r[6]});
            if (done) d = k;
        end
    endtask

    initial begin
        start = 1'b1;
        repeat (2) @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check("rst_outs", {26'd0, sclk, chip_select, mosi, busy, done, 1'b0}, 32'd0);
        check("rst_rx", {16'd0, rx_red, rx_blue}, 32'd0);
        toggles = 0;
        repeat (20) begin
            @(negedge clk);
            if (sclk || chip_select || busy) toggles++;
        end
        check("idle_quiet", toggles, 0);

        run_frame(7'h55, 7'h2A, 16'hC35A, 1'b0, dc);
        check("done_cycle", dc, 137);
        check("mosi_bits", {16'd0, mosi_cap}, 32'h0000AA54);
        check("sclk_pulses", rises, 16);
        check("sclk_phase", bad, 0);
        check("cs_len", cs_len, 136);
        check("busy_at_done", {31'd0, busy}, 32'd0);
        check("rx_at_done", {16'd0, rx_red, rx_blue}, 32'h0000C35A);
        @(negedge clk);
        check("done_pulse", {31'd0, done}, 32'd0);
        check("rx_hold", {16'd0, rx_red, rx_blue}, 32'h0000C35A);

        red_data   = 7'h01;
        blue_data  = 7'h02;
        slave_word = 16'h1234;
        start      = 1'b1;
        for (int k = 1; k <= 139; k++) begin
            @(negedge clk);
            start = (k == 10 || k == 137 || k == 138);
            if (k == 137) check("ign_done", {30'd0, done, busy}, 32'd2);
            if (k == 138) check("ign_in_done", {31'd0, chip_select}, 32'd0);
            if (k == 139) check("restart_cs", {31'd0, chip_select}, 32'd1);
        end
        start = 1'b0;
        dc    = -1;
        for (int k = 140; k <= 400 && dc < 0; k++) begin
            @(negedge clk);
            if (done) dc = k;
        end
        check("restart_done", dc, 138 + 137);

        red_data  = 7'h40;
        blue_data = 7'h40;
        start     = 1'b1;
        for (int k = 1; k <= 61; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 60) rst = 1'b1;
        end
        rst = 1'b0;
        check("abort_outs", {29'd0, sclk, chip_select, busy}, 32'd0);
        check("abort_rx", {16'd0, rx_red, rx_blue}, 32'd0);
        dones = 0;
        repeat (300) begin
            @(negedge clk);
            if (done || chip_select) dones++;
        end
        check("abort_no_done", dones, 0);

        run_frame(7'h13, 7'h7F, 16'h9E01, 1'b0, dc);
        check("post_rst_done", dc, 137);
        check("post_rst_mosi", {16'd0, mosi_cap}, 32'h000026FE);
        check("post_rst_rx", {16'd0, rx_red, rx_blue}, 32'h00009E01);
        @(negedge clk);

        run_frame(7'h0F, 7'h70, 16'h3C81, 1'b1, dc);
        check("stable_done", dc, 137);
        check("stable_mosi", {16'd0, mosi_cap}, 32'h00001EE0);
        check("stable_rx", {16'd0, rx_red, rx_blue}, 32'h00003C81);
        check("stable_pulses", rises, 16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
